axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_master.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: accepts one command at a time, runs the
// write or read channel handshakes, and reports completion or timeout with a one-cycle pulse.
module axi_lite_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic [DATA_WIDTH-1:0] rData,
  input  logic                  rvalid
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  err_q;
  logic [7:0]            count;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic timed_out;
  logic completed;
  logic active;

  assign accept    = cmd_valid && cmd_ready;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign ar_hs     = arvalid && arready;
  assign timed_out = (count == TIMEOUT_LAST);
  assign completed = ((state == WR_RESP) && wresp) || ((state == RD_DATA) && rvalid);
  assign active    = (state == WR_ADDR) || (state == WR_RESP) ||
                     (state == RD_ADDR) || (state == RD_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Direction is carried by the state itself, so cmd_write needs no register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = cmd_write ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_next = WR_RESP;
        end else if (timed_out) begin
          state_next = DONE;
        end
      end
      WR_RESP: begin
        if (wresp || timed_out) begin
          state_next = DONE;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          state_next = RD_DATA;
        end else if (timed_out) begin
          state_next = DONE;
        end
      end
      RD_DATA: begin
        if (rvalid || timed_out) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    arvalid   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: cmd_ready = !rst;
      WR_ADDR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      RD_ADDR: arvalid   = 1'b1;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Any entry into DONE that is not a real completion is a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
      if (state == WR_ADDR) begin
        if (aw_hs) begin
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          w_done <= 1'b1;
        end
      end
      if ((state == RD_DATA) && rvalid) begin
        rdata_q <= rData;
      end
      if ((state_next == DONE) && !completed) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (state_next != state) begin
      count <= '0;
    end else if (active) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: registered-ready AXI-Lite slave model,
// scoreboard of expected responses, one task per scenario.
module tb_axi_lite_master;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int TO = 16;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic          wresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [DW-1:0] rData;
  logic          rvalid;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  exp_t          sb[$];
  logic [DW-1:0] model_regs [4];

  axi_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wresp(wresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rData(rData), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Slave model: one-cycle registered ready pulses, response one cycle after the handshakes.
  logic [DW-1:0] regs [4];
  int            w_extra     = 0;
  bit            block_addr0 = 1'b0;
  bit            rvalid_off  = 1'b0;
  logic          aw_got;
  logic          w_got;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  int            w_wait;

  always @(posedge clk) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; wresp <= 1'b0;
      arready <= 1'b0; rvalid <= 1'b0; rData <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_wait <= 0;
      regs[0] <= 32'h0; regs[1] <= 32'h12345678;
      regs[2] <= 32'h0; regs[3] <= 32'hA5A55A5A;
    end else begin
      awready <= 1'b0; wready <= 1'b0; wresp <= 1'b0;
      arready <= 1'b0; rvalid <= 1'b0;
      rData   <= $urandom;
      if (awvalid && awready) begin
        aw_got <= 1'b1;
        aw_a   <= awaddr;
      end else if (awvalid && !aw_got) begin
        awready <= 1'b1;
      end
      if (wvalid && wready) begin
        w_got  <= 1'b1;
        w_d    <= wdata;
        w_wait <= 0;
      end else if (wvalid && !w_got) begin
        if (w_wait >= w_extra) wready <= 1'b1;
        w_wait <= w_wait + 1;
      end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        regs[aw_got ? aw_a : awaddr] <= (w_got ? w_d : wdata);
        if (!(block_addr0 && ((aw_got ? aw_a : awaddr) == '0))) wresp <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (arvalid && arready) begin
        if (!rvalid_off) begin
          rvalid <= 1'b1;
          rData  <= regs[araddr];
        end
      end else if (arvalid) begin
        arready <= 1'b1;
      end
    end
  end

  int rsp_count   = 0;
  int aw_hs_count = 0;
  int w_hs_count  = 0;
  int ar_hs_count = 0;
  int both_cnt    = 0;
  int wonly_cnt   = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if (rsp_valid) rsp_count++;
    if (awvalid && awready) aw_hs_count++;
    if (wvalid && wready) w_hs_count++;
    if (arvalid && arready) ar_hs_count++;
    if (awvalid && wvalid) both_cnt++;
    if (wvalid && !awvalid) wonly_cnt++;
    if (rsp_valid && (awvalid || wvalid || arvalid)) overlap_cnt++;
    if (cmd_ready && (awvalid || wvalid || arvalid)) overlap_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    model_regs[0] = 32'h0;
    model_regs[1] = 32'h12345678;
    model_regs[2] = 32'h0;
    model_regs[3] = 32'hA5A55A5A;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (cmd_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_compared++; n_mismatched++;
      $display("[TB] FAIL cmd_accept: cmd_ready=%b required=1", cmd_ready);
    end else if (wr) begin
      model_regs[a] = d;
      sb.push_back('{err: (block_addr0 && (a == '0)), rdata: '0});
    end else begin
      sb.push_back('{err: 1'b0, rdata: model_regs[a]});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_compared++;
    if (cmd_ready !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_cmd_ready: got %b required 0", cmd_ready);
    end
    n_compared++;
    if ({awvalid, wvalid, arvalid, rsp_valid} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valids: got %b required 0000", {awvalid, wvalid, arvalid, rsp_valid});
    end
    n_compared++;
    if ({rsp_err, rsp_rdata} !== '0) begin
      n_mismatched++; $display("[TB] FAIL reset_rsp: got err=%b rdata=%h required 0/0", rsp_err, rsp_rdata);
    end
    n_compared++;
    if ({awaddr, araddr, wdata} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_addr_data: got aw=%h ar=%h wd=%h required 0", awaddr, araddr, wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_compared++;
    if (cmd_ready !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL post_reset_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int lat; int aw0; int w0; int r0; exp_t e;
    aw0 = aw_hs_count; w0 = w_hs_count; r0 = rsp_count;
    issue_cmd(1'b1, 2'd2, 32'hDEADBEEF);
    wait_rsp(lat);
    n_compared++;
    if (!rsp_valid || (lat + 1) != 4) begin
      n_mismatched++; $display("[TB] FAIL write_latency: got %0d (rsp_valid=%b) required 4", lat + 1, rsp_valid);
    end
    e = '{err: 1'b1, rdata: 32'hFFFFFFFF};
    if (sb.size() != 0) e = sb.pop_front();
    n_compared++;
    if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
      n_mismatched++;
      $display("[TB] FAIL write_rsp: got err=%b rdata=%h required err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
    end
    repeat (3) @(negedge clk);
    n_compared++;
    if (regs[2] !== 32'hDEADBEEF) begin
      n_mismatched++; $display("[TB] FAIL write_reg2: got %h required DEADBEEF", regs[2]);
    end
    n_compared++;
    if ((aw_hs_count - aw0) != 1 || (w_hs_count - w0) != 1) begin
      n_mismatched++;
      $display("[TB] FAIL write_handshakes: got aw=%0d w=%0d required 1/1", aw_hs_count - aw0, w_hs_count - w0);
    end
    n_compared++;
    if ((rsp_count - r0) != 1 || cmd_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL write_single_rsp: got rsp=%0d ready=%b required 1/1", rsp_count - r0, cmd_ready);
    end
  endtask

  task automatic test_read();
    int lat; int ar0; exp_t e;
    ar0 = ar_hs_count;
    issue_cmd(1'b0, 2'd1, '0);
    wait_rsp(lat);
    n_compared++;
    if (!rsp_valid || (lat + 1) != 4) begin
      n_mismatched++; $display("[TB] FAIL read_latency: got %0d (rsp_valid=%b) required 4", lat + 1, rsp_valid);
    end
    e = '{err: 1'b1, rdata: 32'hFFFFFFFF};
    if (sb.size() != 0) e = sb.pop_front();
    n_compared++;
    if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
      n_mismatched++;
      $display("[TB] FAIL read_rsp: got err=%b rdata=%h required err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
    end
    repeat (2) @(negedge clk);
    n_compared++;
    if ((ar_hs_count - ar0) != 1) begin
      n_mismatched++; $display("[TB] FAIL read_ar_handshake: got %0d required 1", ar_hs_count - ar0);
    end
  endtask

  task automatic test_timeout();
    int n = 0; int entry = -1; bit aw_s = 1'b0; bit w_s = 1'b0; exp_t e;
    block_addr0 = 1'b1;
    issue_cmd(1'b1, 2'd0, 32'h11112222);
    while (!rsp_valid && n < 100) begin
      if (awvalid && awready) aw_s = 1'b1;
      if (wvalid && wready) w_s = 1'b1;
      if (aw_s && w_s && entry < 0) entry = n + 1;
      @(negedge clk);
      n++;
    end
    n_compared++;
    if (!rsp_valid || entry < 0 || (n - entry) != TO) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_length: got %0d (rsp_valid=%b) required %0d", n - entry, rsp_valid, TO);
    end
    e = '{err: 1'b0, rdata: 32'hFFFFFFFF};
    if (sb.size() != 0) e = sb.pop_front();
    n_compared++;
    if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_rsp: got err=%b rdata=%h required err=%b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
    end
    @(negedge clk);
    n_compared++;
    if (cmd_ready !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL timeout_ready: got %b required 1", cmd_ready);
    end
    block_addr0 = 1'b0;
  endtask

  task automatic test_wready_delay();
    int lat; int b0; int wo0; int r0; exp_t e;
    w_extra = 3;
    b0 = both_cnt; wo0 = wonly_cnt; r0 = rsp_count;
    issue_cmd(1'b1, 2'd3, 32'hCAFEF00D);
    wait_rsp(lat);
    e = '{err: 1'b1, rdata: 32'hFFFFFFFF};
    if (sb.size() != 0) e = sb.pop_front();
    n_compared++;
    if (!rsp_valid || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
      n_mismatched++;
      $display("[TB] FAIL wdelay_rsp: got v=%b err=%b rdata=%h required v=1 err=%b rdata=%h",
               rsp_valid, rsp_err, rsp_rdata, e.err, e.rdata);
    end
    repeat (4) @(negedge clk);
    n_compared++;
    if ((both_cnt - b0) != 2 || (wonly_cnt - wo0) != 3) begin
      n_mismatched++;
      $display("[TB] FAIL wdelay_valids: got both=%0d wonly=%0d required 2/3", both_cnt - b0, wonly_cnt - wo0);
    end
    n_compared++;
    if ((rsp_count - r0) != 1 || regs[3] !== 32'hCAFEF00D) begin
      n_mismatched++;
      $display("[TB] FAIL wdelay_result: got rsp=%0d reg3=%h required 1/CAFEF00D", rsp_count - r0, regs[3]);
    end
    w_extra = 0;
  endtask

  task automatic test_reset_mid();
    int r0;
    rvalid_off = 1'b1;
    r0 = rsp_count;
    issue_cmd(1'b0, 2'd1, '0);
    repeat (2) @(negedge clk);
    n_compared++;
    if (arvalid !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL rd_data_arvalid: got %b required 0", arvalid);
    end
    rst = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({awvalid, wvalid, arvalid, rsp_valid, cmd_ready} !== 5'b00000) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_outputs: got %b required 00000", {awvalid, wvalid, arvalid, rsp_valid, cmd_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    n_compared++;
    if (cmd_ready !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL midreset_ready: got %b required 1", cmd_ready);
    end
    repeat (3) @(negedge clk);
    n_compared++;
    if ((rsp_count - r0) != 0) begin
      n_mismatched++; $display("[TB] FAIL midreset_no_rsp: got %0d required 0", rsp_count - r0);
    end
    sb.delete();
    model_reset();
    rvalid_off = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nacc = 0; int nrsp = 0; int acc_cyc[2]; int rsp_cyc[2]; int ov0; exp_t e;
    ov0 = overlap_cnt;
    acc_cyc[0] = 0; acc_cyc[1] = 0; rsp_cyc[0] = 0; rsp_cyc[1] = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd3; cmd_wdata = 32'h0BADF00D;
    for (int n = 0; n < 80 && nrsp < 2; n++) begin
      if (rsp_valid) begin
        rsp_cyc[nrsp] = cyc;
        nrsp++;
        e = '{err: 1'b1, rdata: 32'hFFFFFFFF};
        if (sb.size() != 0) e = sb.pop_front();
        n_compared++;
        if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_rsp%0d: got err=%b rdata=%h required err=%b rdata=%h",
                   nrsp, rsp_err, rsp_rdata, e.err, e.rdata);
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (nacc < 2) acc_cyc[nacc] = cyc;
        nacc++;
        if (cmd_write) begin
          model_regs[cmd_addr] = cmd_wdata;
          sb.push_back('{err: 1'b0, rdata: '0});
        end else begin
          sb.push_back('{err: 1'b0, rdata: model_regs[cmd_addr]});
        end
      end
      @(negedge clk);
      if (nacc == 1) begin
        cmd_write = 1'b0;
        cmd_addr  = 2'd3;
      end
      if (nacc >= 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    n_compared++;
    if (nacc != 2 || nrsp != 2) begin
      n_mismatched++; $display("[TB] FAIL b2b_counts: got acc=%0d rsp=%0d required 2/2", nacc, nrsp);
    end
    n_compared++;
    if (acc_cyc[1] <= rsp_cyc[0]) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_order: got second accept cycle %0d, required after first rsp cycle %0d",
               acc_cyc[1], rsp_cyc[0]);
    end
    n_compared++;
    if ((overlap_cnt - ov0) != 0) begin
      n_mismatched++; $display("[TB] FAIL b2b_overlap: got %0d required 0", overlap_cnt - ov0);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    model_reset();
    $display("[TB] start");
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_wready_delay();
    test_reset_mid();
    test_back_to_back();
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++; $display("[TB] FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
